// File: rtl/dct_top.sv
// ============================================================================
// Module      : dct_top
// Description : 8x8 separable 2-D DCT-II. Rows are transformed on load into a
//               transpose buffer; the column DCT is applied during readout.
//               Optional out_valid port enabled by defining DCT_VALID_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dct_top (
    input  logic               clk,
    input  logic               rst,
`ifdef DCT_VALID_EN
    output logic               out_valid,
`endif
    input  logic               en,
    input  logic [7:0]         x0,
    input  logic [7:0]         x1,
    input  logic [7:0]         x2,
    input  logic [7:0]         x3,
    input  logic [7:0]         x4,
    input  logic [7:0]         x5,
    input  logic [7:0]         x6,
    input  logic [7:0]         x7,
    output logic signed [13:0] y0,
    output logic signed [13:0] y1,
    output logic signed [13:0] y2,
    output logic signed [13:0] y3,
    output logic signed [13:0] y4,
    output logic signed [13:0] y5,
    output logic signed [13:0] y6,
    output logic signed [13:0] y7
);

    // K(k,n) = +/-c[m] where m = (2n+1)k folded into the first quadrant.
    function automatic logic signed [13:0] coef(input logic [2:0] k, input logic [2:0] n);
        logic [4:0]         mm;
        logic [4:0]         idx;
        logic               neg;
        logic signed [13:0] mag;
        mm  = {1'b0, n, 1'b1} * {2'b00, k};
        idx = (mm > 5'd16) ? (5'd0 - mm) : mm;
        neg = 1'b0;
        if (idx > 5'd8) begin
            neg = 1'b1;
            idx = 5'd16 - idx;
        end
        case (idx)
            5'd0:    mag = 14'sd2048;
            5'd1:    mag = 14'sd2009;
            5'd2:    mag = 14'sd1892;
            5'd3:    mag = 14'sd1703;
            5'd4:    mag = 14'sd1448;
            5'd5:    mag = 14'sd1138;
            5'd6:    mag = 14'sd784;
            5'd7:    mag = 14'sd400;
            default: mag = 14'sd0;
        endcase
        if (k == 3'd0) begin
            mag = 14'sd1448;
            neg = 1'b0;
        end
        return neg ? -mag : mag;
    endfunction

    logic [7:0]         w_x    [8];
    logic signed [23:0] w_trow [8];
    logic signed [13:0] w_yrow [8];
    logic [2:0]         w_wr_row;

    logic signed [23:0] r_t    [8][8];
    logic signed [13:0] r_y    [8];
    logic [2:0]         r_lp;
    logic [3:0]         r_op;
    logic               r_rd;
    logic               r_valid;

    assign w_x[0] = x0;
    assign w_x[1] = x1;
    assign w_x[2] = x2;
    assign w_x[3] = x3;
    assign w_x[4] = x4;
    assign w_x[5] = x5;
    assign w_x[6] = x6;
    assign w_x[7] = x7;

    // First load after any readout restarts the block at buffer row 0.
    assign w_wr_row = r_rd ? 3'd0 : r_lp;

    always_comb begin
        logic signed [23:0] kk;
        logic signed [23:0] xx;
        for (int k = 0; k < 8; k++) begin
            w_trow[k] = '0;
            for (int n = 0; n < 8; n++) begin
                kk        = 24'(coef(3'(k), 3'(n)));
                xx        = {16'd0, w_x[n]};
                w_trow[k] = w_trow[k] + kk * xx;
            end
        end
    end

    always_comb begin
        logic signed [39:0] acc;
        logic signed [39:0] kk;
        logic signed [39:0] tt;
        logic signed [39:0] sh;
        for (int j = 0; j < 8; j++) begin
            acc = '0;
            for (int r = 0; r < 8; r++) begin
                kk  = 40'(coef(r_op[2:0], 3'(r)));
                tt  = 40'(r_t[r][j]);
                acc = acc + kk * tt;
            end
            sh = (acc + 40'sd8388608) >>> 24;
            if (sh > 40'sd8191)
                w_yrow[j] = 14'sd8191;
            else if (sh < -40'sd8192)
                w_yrow[j] = -14'sd8192;
            else
                w_yrow[j] = sh[13:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 8; r++) begin
                r_y[r] <= '0;
                for (int c = 0; c < 8; c++)
                    r_t[r][c] <= '0;
            end
            r_lp    <= '0;
            r_op    <= '0;
            r_rd    <= 1'b0;
            r_valid <= 1'b0;
        end else if (en) begin
            r_t[w_wr_row] <= w_trow;
            r_lp          <= w_wr_row + 3'd1;
            r_op          <= '0;
            r_rd          <= 1'b0;
            r_valid       <= 1'b0;
        end else begin
            r_rd <= 1'b1;
            if (!r_op[3]) begin
                r_y     <= w_yrow;
                r_op    <= r_op + 4'd1;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef DCT_VALID_EN
    assign out_valid = r_valid;
`else
    logic w_unused;
    assign w_unused = r_valid;
`endif

    assign y0 = r_y[0];
    assign y1 = r_y[1];
    assign y2 = r_y[2];
    assign y3 = r_y[3];
    assign y4 = r_y[4];
    assign y5 = r_y[5];
    assign y6 = r_y[6];
    assign y7 = r_y[7];

endmodule

`default_nettype wire

// File: tb/tb_dct_top.sv
// ============================================================================
// Module      : tb_dct_top
// Description : Self-checking bench for dct_top against a matrix-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dct_top;

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic [7:0] x0, x1, x2, x3, x4, x5, x6, x7;
    logic signed [13:0] y0, y1, y2, y3, y4, y5, y6, y7;
`ifdef DCT_VALID_EN
    logic out_valid;
`endif

    dct_top dut (
        .clk(clk), .rst(rst),
`ifdef DCT_VALID_EN
        .out_valid(out_valid),
`endif
        .en(en),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .x5(x5), .x6(x6), .x7(x7),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7)
    );

    always #5 clk = ~clk;

    // Reference model state: coefficient matrix, transpose buffer, pointers.
    longint kt [8][8];
    longint mb [8][8];
    longint my [8];
    int     mlp, mop;
    bit     mrd, mval;
    int     checks = 0;
    int     errors = 0;
    int     px [8];

    function automatic logic signed [63:0] get_y(input int j);
        case (j)
            0: return 64'(y0);
            1: return 64'(y1);
            2: return 64'(y2);
            3: return 64'(y3);
            4: return 64'(y4);
            5: return 64'(y5);
            6: return 64'(y6);
            default: return 64'(y7);
        endcase
    endfunction

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int j = 0; j < 8; j++)
            chk($sformatf("%s_y%0d", tag, j), get_y(j), 64'(my[j]));
`ifdef DCT_VALID_EN
        chk($sformatf("%s_valid", tag), 64'(out_valid), 64'(mval));
`endif
    endtask

    task automatic model_reset();
        for (int r = 0; r < 8; r++) begin
            my[r] = 0;
            for (int c = 0; c < 8; c++) mb[r][c] = 0;
        end
        mlp = 0; mop = 0; mrd = 0; mval = 0;
    endtask

    task automatic drive_x();
        x0 = 8'(px[0]); x1 = 8'(px[1]); x2 = 8'(px[2]); x3 = 8'(px[3]);
        x4 = 8'(px[4]); x5 = 8'(px[5]); x6 = 8'(px[6]); x7 = 8'(px[7]);
    endtask

    task automatic load_row(input string tag);
        en = 1'b1;
        drive_x();
        @(posedge clk); #1;
        if (mrd) mlp = 0;
        mrd = 0;
        for (int k = 0; k < 8; k++) begin
            mb[mlp][k] = 0;
            for (int n = 0; n < 8; n++) mb[mlp][k] += kt[k][n] * px[n];
        end
        mlp = (mlp + 1) % 8;
        mop = 0;
        mval = 0;
        check_all(tag);
    endtask

    task automatic read_row(input string tag);
        longint p, v;
        en = 1'b0;
        for (int n = 0; n < 8; n++) px[n] = $urandom_range(255);
        drive_x();
        @(posedge clk); #1;
        mrd = 1;
        if (mop < 8) begin
            for (int j = 0; j < 8; j++) begin
                p = 0;
                for (int r = 0; r < 8; r++) p += kt[mop][r] * mb[r][j];
                v = (p + 64'sd8388608) >>> 24;
                my[j] = (v > 8191) ? 8191 : (v < -8192) ? -8192 : v;
            end
            mop++;
            mval = 1;
        end else begin
            mval = 0;
        end
        check_all(tag);
    endtask

    task automatic fill(input int v);
        for (int n = 0; n < 8; n++) px[n] = v;
    endtask

    task automatic randx();
        for (int n = 0; n < 8; n++) px[n] = $urandom_range(255);
    endtask

    task automatic load_block(input string tag, input int rows, input bit rnd);
        for (int r = 0; r < rows; r++) begin
            if (rnd) randx();
            load_row(tag);
        end
    endtask

    task automatic read_block(input string tag, input int rows);
        for (int r = 0; r < rows; r++) read_row(tag);
    endtask

    initial begin
        real a, v;
        for (int k = 0; k < 8; k++)
            for (int n = 0; n < 8; n++) begin
                a = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
                v = 4096.0 * a * $cos((2 * n + 1) * k * 3.14159265358979 / 16.0);
                kt[k][n] = (v >= 0.0) ? longint'($floor(v + 0.5)) : -longint'($floor(-v + 0.5));
            end

        // Reset with random inputs: outputs clear immediately and stay clear.
        rst = 1'b1;
        en  = 1'($urandom_range(1));
        randx();
        drive_x();
        model_reset();
        #1;
        check_all("rst_now");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            en = 1'($urandom_range(1));
            randx();
            drive_x();
            check_all("rst_hold");
        end
        @(negedge clk);
        rst = 1'b0;

        fill(0);   load_block("zero_ld", 8, 0);  read_block("zero_rd", 8);

        fill(255); load_block("w255_ld", 8, 0);
        read_row("w255_r0");
        chk("w255_dc", get_y(0), 2040);
        read_block("w255_rd", 7);

        fill(128); load_block("w128_ld", 8, 0);
        read_row("w128_r0");
        chk("w128_dc", get_y(0), 1024);
        read_block("w128_rd", 7);

        px = '{255, 255, 255, 255, 0, 0, 0, 0};
        load_block("stripe_ld", 8, 0);
        read_row("stripe_r0");
        chk("stripe_y0", get_y(0), 1020);
        chk("stripe_y1", get_y(1), 924);
        chk("stripe_y2", get_y(2), 0);
        chk("stripe_y3", get_y(3), -325);
        chk("stripe_y4", get_y(4), 0);
        chk("stripe_y5", get_y(5), 217);
        chk("stripe_y6", get_y(6), 0);
        chk("stripe_y7", get_y(7), -184);
        read_block("stripe_rd", 7);

        // Back-to-back block, then extra readout cycles hold row 7.
        fill(255); load_block("b2b_ld", 8, 0);
        read_row("b2b_r0");
        chk("b2b_dc", get_y(0), 2040);
        read_block("b2b_rd", 7);
        read_block("b2b_hold", 3);

        for (int b = 0; b < 4; b++) begin
            load_block("rnd_ld", 8, 1);
            read_block("rnd_rd", 8);
        end

        load_block("prem_ld", 3, 1);  read_block("prem_rd", 9);
        load_block("wrap_ld", 11, 1); read_block("wrap_rd", 8);
        load_block("abort_ld", 8, 1); read_block("abort_rd", 3);
        load_block("abort2_ld", 8, 1); read_block("abort2_rd", 8);

        // Asynchronous reset in the middle of a readout.
        load_block("mid_ld", 8, 1);
        read_block("mid_rd", 2);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        load_block("post_ld", 8, 1);
        read_block("post_rd", 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
